// File: rtl/clk_gen_cfg_bridge.sv
// clk_gen_cfg_bridge: APB slave that turns each transfer into one timeout-bounded cfg transaction
module clk_gen_cfg_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        cfg_req_o,
  input  logic        cfg_ack_i,
  output logic [3:0]  cfg_add_o,
  output logic [31:0] cfg_data_o,
  output logic        cfg_wrn_o,
  input  logic [31:0] cfg_r_data_i,
  output logic        timeout_o
);
  // REQ and DONE each own one state bit, so cfg_req_o and pready_o come straight off a flop
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10} state_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, wrn_q;
  logic [31:0]      rdata_q, data_q;
  logic [3:0]       add_q;
  logic             setup, ack, expire, done;
  assign setup  = psel_i & ~penable_i;
  assign ack    = (state_q == REQ) & cfg_ack_i;
  assign expire = (state_q == REQ) & ~cfg_ack_i & (TIMEOUT != 0) & (cnt_q == LAST);
  assign done   = state_q == DONE;
  // state register; reset aborts any transfer immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end
  // next state: accept a setup phase, wait for ack or timeout, one ready cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = setup ? REQ : IDLE;
      REQ:     state_d = (ack | expire) ? DONE : REQ;
      default: state_d = IDLE;
    endcase
  end
  // outputs: APB response only visible in DONE, timeout pulse coincides with it
  always_comb begin
    cfg_req_o  = state_q == REQ;
    pready_o   = done;
    pslverr_o  = done & err_q;
    timeout_o  = done & err_q;
    prdata_o   = done ? rdata_q : '0;
    cfg_add_o  = add_q;
    cfg_data_o = data_q;
    cfg_wrn_o  = wrn_q;
  end
  // datapath: latch request on setup, count REQ cycles, capture response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      add_q   <= '0;
      data_q  <= '0;
      wrn_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && setup) begin
        add_q  <= paddr_i[5:2];
        data_q <= pwdata_i;
        wrn_q  <= pwrite_i;
      end
      if (state_q != REQ) cnt_q <= '0;
      else if (!ack && !expire && TIMEOUT != 0 && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      if (ack) begin
        err_q   <= 1'b0;
        rdata_q <= wrn_q ? '0 : cfg_r_data_i;
      end else if (expire) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_clk_gen_cfg_bridge.sv
// tb_clk_gen_cfg_bridge: randomized APB transfers against a transaction-timeline model of the bridge
module tb_clk_gen_cfg_bridge;
  localparam int T = 8;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, ack = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0, rdata_in = '0;
  logic [31:0] prdata_o, cfg_data_o;
  logic        pready_o, pslverr_o, cfg_req_o, cfg_wrn_o, timeout_o;
  logic [3:0]  cfg_add_o;

  clk_gen_cfg_bridge #(.TIMEOUT(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .cfg_req_o(cfg_req_o), .cfg_ack_i(ack), .cfg_add_o(cfg_add_o),
    .cfg_data_o(cfg_data_o), .cfg_wrn_o(cfg_wrn_o), .cfg_r_data_i(rdata_in), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0, cyc = 0, s_cyc = 0;
  int          mon_req = 0, mon_to = 0, rdy_last = 0, rdy_prev = 0;
  logic [31:0] last_rd = '0, last_data = '0;
  logic [3:0]  last_add = '0;
  logic        last_wrn = 1'b0, last_err = 1'b0;
  bit          chk_en = 1'b0;
  logic        exp_req = 1'b0, exp_rdy = 1'b0, exp_err = 1'b0, exp_to = 1'b0, exp_wrn = 1'b0;
  logic [31:0] exp_rd = '0, exp_data = '0;
  logic [3:0]  exp_add = '0;
  int          lit_seq = 0, lit_done = 0;
  string       lit_n = "";
  logic [31:0] lit_a = '0, lit_e = '0;

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  // single checking process: monitor, per-cycle model compare and queued literal checks
  initial forever begin
    @(negedge clk);
    cyc++;
    if (cfg_req_o === 1'b1) begin
      mon_req++;
      last_add = cfg_add_o; last_data = cfg_data_o; last_wrn = cfg_wrn_o;
    end
    if (pready_o === 1'b1) begin
      rdy_prev = rdy_last; rdy_last = cyc; last_rd = prdata_o; last_err = pslverr_o;
    end
    if (timeout_o === 1'b1) mon_to++;
    if (lit_seq != lit_done) begin
      cmp(lit_n, lit_a, lit_e);
      lit_done = lit_seq;
    end
    if (chk_en) begin
      cmp("cfg_req", 32'(cfg_req_o), 32'(exp_req));
      cmp("pready", 32'(pready_o), 32'(exp_rdy));
      cmp("pslverr", 32'(pslverr_o), 32'(exp_err));
      cmp("timeout", 32'(timeout_o), 32'(exp_to));
      cmp("prdata", prdata_o, exp_rd);
      if (exp_req) begin
        cmp("cfg_add", 32'(cfg_add_o), 32'(exp_add));
        cmp("cfg_data", cfg_data_o, exp_data);
        cmp("cfg_wrn", 32'(cfg_wrn_o), 32'(exp_wrn));
      end
    end
  end

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    lit_n = n; lit_a = a; lit_e = e; lit_seq++;
    @(negedge clk); #1;
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    exp_req = 0; exp_rdy = 0; exp_err = 0; exp_to = 0; exp_rd = '0;
  endtask

  // one APB transfer; ack comes after d REQ cycles without it (d >= T means timeout);
  // rst_at > 0 resets in that REQ cycle and abandons the transfer
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd, input int d,
                      input int rst_at, input logic [31:0] frd, input bit fix);
    int          n;
    bit          er;
    logic [31:0] cap;
    n = (d < T) ? d + 1 : T;
    er = d >= T;
    cap = '0;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
    ack = 1'($urandom); rdata_in = $urandom;
    s_cyc = cyc;
    sync();
    for (int i = 1; i <= n; i++) begin
      exp_req = 1; exp_add = a[5:2]; exp_data = wd; exp_wrn = wr;
      penable = 1; psel = ($urandom_range(7) != 0);
      rdata_in = fix ? frd : $urandom;
      ack = (i == d + 1);
      if (ack) cap = wr ? '0 : rdata_in;
      if (i == rst_at) begin
        chk_en = 0; rst_n = 0;
        #1;
        lit("rst_immediate", 32'({pready_o, cfg_req_o, pslverr_o, timeout_o}), 32'h0);
        sync();
        psel = 0; penable = 0; ack = 0;
        set_idle();
        rst_n = 1; chk_en = 1;
        return;
      end
      sync();
    end
    exp_req = 0; exp_rdy = 1; exp_err = er; exp_to = er; exp_rd = er ? '0 : cap;
    psel = 1; penable = 1; ack = 1'($urandom); rdata_in = $urandom;
    sync();
    psel = 0; penable = 0; ack = 1'($urandom);
    set_idle();
  endtask

  int r0, t0;

  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    lit("rst_prdata", prdata_o, 32'h0);
    lit("rst_cfg_data", cfg_data_o, 32'h0);
    lit("rst_ctl", 32'({cfg_add_o, pready_o, pslverr_o, cfg_req_o, cfg_wrn_o, timeout_o}), 32'h0);
    sync();
    rst_n = 1;
    set_idle();
    chk_en = 1;
    sync();
    // write, ack immediately
    r0 = mon_req;
    xfer(1, 12'h008, 32'h0000_00A5, 0, 0, '0, 0);
    lit("w_req_cycles", mon_req - r0, 1);
    lit("w_ready_cycle", rdy_last - s_cyc, 3);
    lit("w_err", 32'(last_err), 0);
    lit("w_add", 32'(last_add), 2);
    lit("w_data", last_data, 32'hA5);
    lit("w_wrn", 32'(last_wrn), 1);
    sync();
    // read, ack after 5 cycles
    r0 = mon_req;
    xfer(0, 12'h03C, $urandom, 5, 0, 32'hDEADDA7A, 1);
    lit("r_req_cycles", mon_req - r0, 6);
    lit("r_prdata", last_rd, 32'hDEADDA7A);
    lit("r_add", 32'(last_add), 15);
    lit("r_wrn", 32'(last_wrn), 0);
    lit("r_err", 32'(last_err), 0);
    sync();
    // timeout
    r0 = mon_req; t0 = mon_to;
    xfer(0, 12'h020, $urandom, 100, 0, 32'h1234_5678, 1);
    lit("to_req_cycles", mon_req - r0, 8);
    lit("to_err", 32'(last_err), 1);
    lit("to_prdata", last_rd, 0);
    lit("to_pulses", mon_to - t0, 1);
    sync();
    // ack in the last allowed cycle
    r0 = mon_req; t0 = mon_to;
    xfer(0, 12'h014, $urandom, 7, 0, 32'hCAFE_0001, 1);
    lit("last_req_cycles", mon_req - r0, 8);
    lit("last_err", 32'(last_err), 0);
    lit("last_prdata", last_rd, 32'hCAFE_0001);
    lit("last_to_pulses", mon_to - t0, 0);
    sync();
    // back-to-back write then read
    r0 = mon_req;
    xfer(1, 12'h004, $urandom, 0, 0, '0, 0);
    xfer(0, 12'h010, $urandom, 0, 0, '0, 0);
    lit("b2b_ready_gap", rdy_last - rdy_prev, 3);
    lit("b2b_req_cycles", mon_req - r0, 2);
    lit("b2b_add", 32'(last_add), 4);
    lit("b2b_wrn", 32'(last_wrn), 0);
    sync();
    // reset in REQ, then a normal write
    xfer(0, 12'h018, $urandom, 100, 3, '0, 0);
    xfer(1, 12'h00C, 32'h0000_1234, 0, 0, '0, 0);
    lit("post_rst_ready_cycle", rdy_last - s_cyc, 3);
    lit("post_rst_add", 32'(last_add), 3);
    lit("post_rst_data", last_data, 32'h1234);
    lit("post_rst_err", 32'(last_err), 0);
    sync();
    // randomized traffic with random gaps and psel drops
    repeat (150) begin
      xfer(1'($urandom), 12'($urandom), $urandom, int'($urandom_range(0, 10)), 0, '0, 0);
      repeat ($urandom_range(0, 2)) sync();
    end
    sync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
